au_satellite_gpio_ctrl: RTL and testbench

//  Parametrised front-end for satellite/CMC GPIO lines and HBM thermal trip.

---
 rtl/au_satellite_gpio_ctrl_pkg.sv | 19 +
 rtl/au_satellite_gpio_ctrl_if.sv | 15 +
 rtl/au_gpio_debounce_ch.sv | 51 +++++
 rtl/au_satellite_gpio_ctrl.sv | 118 +++++++++++
 tb/tb_au_satellite_gpio_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/au_satellite_gpio_ctrl_pkg.sv
// rtl/au_satellite_gpio_ctrl_pkg.sv - shared types and helpers for the satellite GPIO front-end
// Purpose: clear-handshake state encoding and the saturating counter increment.
// Ports: none (package au_sat_pkg).
package au_sat_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } clr_state_t;

  // Increment that sticks at 2^width-1 instead of wrapping; width up to 32.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (cnt >= max_val) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/au_satellite_gpio_ctrl_if.sv
// rtl/au_satellite_gpio_ctrl_if.sv - clear request/acknowledge bundle
// Purpose: groups the clear handshake between a host (master) and the GPIO block (slave).
// Signals: clr_req (level request), clr_sel (channels to clear), clr_ack (1-cycle ack).
interface au_satellite_gpio_ctrl_if #(
  parameter int NUM_GPIO = 2
) ();

  logic                clr_req;
  logic [NUM_GPIO-1:0] clr_sel;
  logic                clr_ack;

  modport master (output clr_req, output clr_sel, input clr_ack);
  modport slave  (input clr_req, input clr_sel, output clr_ack);

endinterface

// File: rtl/au_gpio_debounce_ch.sv
// rtl/au_gpio_debounce_ch.sv - one-channel synchroniser, debouncer and edge detector
// Purpose: 2-flop sync of an async input, then accept a new value only after it has
//   differed from the stable value for DEBOUNCE_CYCLES consecutive synced samples.
// Ports: clk, rst_n (async active-low), din (raw async input),
//   level (debounced value), rise / fall (1-cycle pulses coincident with level update).
module au_gpio_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == level) begin
        // Any return to the stable value restarts qualification.
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync2;
        cnt   <= '0;
        rise  <= sync2;
        fall  <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/au_satellite_gpio_ctrl.sv
// rtl/au_satellite_gpio_ctrl.sv - satellite/CMC GPIO front-end with HBM cattrip latch
// Purpose: debounces NUM_GPIO async inputs, keeps sticky flags and saturating rise
//   counters cleared through a req/ack handshake, and latches hbm_cattrip_o.
// Ports: s_axi_aclk, s_axi_aresetn (async active-low), gpio_in, gpio_mask,
//   gpio_level, gpio_rise, gpio_fall, sticky, evt_count (ch0 in LSBs), irq,
//   clr_if (slave: clr_req, clr_sel, clr_ack), hbm_cattrip_o.
module au_satellite_gpio_ctrl
  import au_sat_pkg::*;
#(
  parameter int                  NUM_GPIO        = 2,
  parameter int                  DEBOUNCE_CYCLES = 16,
  parameter int                  CNT_W           = 16,
  parameter logic [NUM_GPIO-1:0] CATTRIP_MAP     = '0
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  input  logic [NUM_GPIO-1:0]       gpio_in,
  input  logic [NUM_GPIO-1:0]       gpio_mask,
  output logic [NUM_GPIO-1:0]       gpio_level,
  output logic [NUM_GPIO-1:0]       gpio_rise,
  output logic [NUM_GPIO-1:0]       gpio_fall,
  output logic [NUM_GPIO-1:0]       sticky,
  output logic [NUM_GPIO*CNT_W-1:0] evt_count,
  output logic                      irq,
  au_satellite_gpio_ctrl_if.slave   clr_if,
  output logic                      hbm_cattrip_o
);

  clr_state_t          clr_state;
  logic                clr_fire;
  logic [NUM_GPIO-1:0] clr_mask;
  logic [NUM_GPIO-1:0] sticky_nxt;
  logic [CNT_W-1:0]    cnt_q [NUM_GPIO];
  logic                cattrip_q;
  logic                cattrip_now;

  for (genvar g = 0; g < NUM_GPIO; g++) begin : g_ch
    au_gpio_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (s_axi_aclk),
      .rst_n(s_axi_aresetn),
      .din  (gpio_in[g]),
      .level(gpio_level[g]),
      .rise (gpio_rise[g]),
      .fall (gpio_fall[g])
    );
    assign evt_count[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  // A clear only acts on the cycle the handshake leaves IDLE.
  assign clr_fire = (clr_state == IDLE) && clr_if.clr_req;
  assign clr_mask = clr_fire ? clr_if.clr_sel : '0;

  // Clear first, then set: a rise landing on the clear cycle survives.
  assign sticky_nxt = (sticky & ~clr_mask) | (gpio_rise & ~gpio_mask);

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      sticky <= '0;
      irq    <= 1'b0;
      for (int i = 0; i < NUM_GPIO; i++) cnt_q[i] <= '0;
    end else begin
      sticky <= sticky_nxt;
      irq    <= |sticky_nxt;
      for (int i = 0; i < NUM_GPIO; i++) begin
        if (clr_mask[i]) begin
          cnt_q[i] <= gpio_rise[i] ? CNT_W'(1) : '0;
        end else if (gpio_rise[i]) begin
          cnt_q[i] <= CNT_W'(sat_inc(32'(cnt_q[i]), CNT_W));
        end
      end
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      clr_state      <= IDLE;
      clr_if.clr_ack <= 1'b0;
    end else begin
      case (clr_state)
        IDLE: begin
          clr_if.clr_ack <= 1'b0;
          if (clr_if.clr_req) begin
            clr_state      <= ACK;
            clr_if.clr_ack <= 1'b1;
          end
        end
        ACK: begin
          clr_if.clr_ack <= 1'b0;
          clr_state      <= WAIT;
        end
        WAIT: begin
          clr_if.clr_ack <= 1'b0;
          if (!clr_if.clr_req) clr_state <= IDLE;
        end
        default: begin
          clr_if.clr_ack <= 1'b0;
          clr_state      <= IDLE;
        end
      endcase
    end
  end

  // The live term makes the trip visible in the same cycle the level rises;
  // the flop holds it afterwards until reset.
  assign cattrip_now   = |(gpio_level & CATTRIP_MAP);
  assign hbm_cattrip_o = cattrip_q | cattrip_now;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      cattrip_q <= 1'b0;
    end else if (cattrip_now) begin
      cattrip_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_au_satellite_gpio_ctrl.sv
// tb/tb_au_satellite_gpio_ctrl.sv - self-checking bench for au_satellite_gpio_ctrl
module tb_au_satellite_gpio_ctrl;

  localparam int         N    = 2;
  localparam int         D    = 4;
  localparam int         CW   = 4;
  localparam logic [1:0] MAP  = 2'b10;
  localparam int         CMAX = 15;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  gpio_in;
  logic [N-1:0]  gpio_mask;
  logic [N-1:0]  gpio_level;
  logic [N-1:0]  gpio_rise;
  logic [N-1:0]  gpio_fall;
  logic [N-1:0]  sticky;
  logic [N*CW-1:0] evt_count;
  logic          irq;
  logic          hbm_cattrip_o;

  au_satellite_gpio_ctrl_if #(.NUM_GPIO(N)) clr_if ();

  au_satellite_gpio_ctrl #(
    .NUM_GPIO(N), .DEBOUNCE_CYCLES(D), .CNT_W(CW), .CATTRIP_MAP(MAP)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .gpio_in      (gpio_in),
    .gpio_mask    (gpio_mask),
    .gpio_level   (gpio_level),
    .gpio_rise    (gpio_rise),
    .gpio_fall    (gpio_fall),
    .sticky       (sticky),
    .evt_count    (evt_count),
    .irq          (irq),
    .clr_if       (clr_if),
    .hbm_cattrip_o(hbm_cattrip_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: the input seen two samples late must disagree with the
  // accepted level for D consecutive samples before the level follows it.
  logic [N-1:0] m_d1, m_d2, m_lvl, m_rise, m_fall, m_st;
  int           m_run [N];
  int           m_cnt [N];
  logic         m_irq, m_ack, m_cat, m_armed;
  int           m_since;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_st = '0;
    for (int i = 0; i < N; i++) begin m_run[i] = 0; m_cnt[i] = 0; end
    m_irq = 0; m_ack = 0; m_cat = 0; m_armed = 1; m_since = 0;
  endtask

  task automatic check_all();
    chk("level", 32'(gpio_level), 32'(m_lvl));
    chk("rise", 32'(gpio_rise), 32'(m_rise));
    chk("fall", 32'(gpio_fall), 32'(m_fall));
    chk("sticky", 32'(sticky), 32'(m_st));
    chk("evt_count", 32'(evt_count), 32'({m_cnt[1][3:0], m_cnt[0][3:0]}));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("clr_ack", 32'(clr_if.clr_ack), 32'(m_ack));
    chk("cattrip", 32'(hbm_cattrip_o), 32'(m_cat));
  endtask

  task automatic step();
    logic         fire;
    logic [N-1:0] sel;
    @(posedge clk);
    fire = m_armed && clr_if.clr_req;
    sel  = fire ? clr_if.clr_sel : '0;
    for (int i = 0; i < N; i++) begin
      if (sel[i]) m_cnt[i] = m_rise[i] ? 1 : 0;
      else if (m_rise[i]) m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
    end
    m_st  = (m_st & ~sel) | (m_rise & ~gpio_mask);
    m_irq = |m_st;
    m_ack = fire;
    if (fire) begin
      m_armed = 0; m_since = 0;
    end else if (!m_armed) begin
      m_since++;
      if (m_since >= 2 && !clr_if.clr_req) m_armed = 1;
    end
    for (int i = 0; i < N; i++) begin
      m_rise[i] = 0; m_fall[i] = 0;
      if (m_d2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_lvl[i] = m_d2[i]; m_rise[i] = m_d2[i]; m_fall[i] = ~m_d2[i]; m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_d2 = m_d1;
    m_d1 = gpio_in;
    if ((m_lvl & MAP) != 0) m_cat = 1;
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Assert reset mid-cycle, check it takes effect at once, release mid-cycle.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  int k, cnt_ev, hold0, hold1;
  logic found;

  initial begin
    rst_n = 1'b0; gpio_in = '0; gpio_mask = '0;
    clr_if.clr_req = 1'b0; clr_if.clr_sel = '0;
    model_reset();
    #1 check_all();
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    steps(3);

    // 1: clean rise, latency 2+D, then sticky/irq/count one cycle later
    gpio_in[0] = 1'b1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin step(); if (gpio_level[0]) begin k = i; break; end end
    chk("t1_latency", 32'(k), 32'(D + 2));
    chk("t1_rise", 32'(gpio_rise[0]), 32'd1);
    step();
    chk("t1_sticky", 32'(sticky[0]), 32'd1);
    chk("t1_irq", 32'(irq), 32'd1);
    chk("t1_count", 32'(evt_count[CW-1:0]), 32'd1);
    gpio_in[0] = 1'b0;
    steps(10);

    // 2: glitch of 3 cycles is rejected
    gpio_in[0] = 1'b1;
    cnt_ev = 0;
    for (int i = 0; i < 3; i++) begin step(); cnt_ev += int'(gpio_rise[0]) + int'(gpio_fall[0]); end
    gpio_in[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin step(); cnt_ev += int'(gpio_rise[0]) + int'(gpio_fall[0]); end
    chk("t2_pulses", 32'(cnt_ev), 32'd0);
    chk("t2_level", 32'(gpio_level[0]), 32'd0);
    chk("t2_count", 32'(evt_count[CW-1:0]), 32'd1);

    // 3: 20 clean cycles saturate the counter
    cnt_ev = 0;
    for (int c = 0; c < 20; c++) begin
      gpio_in[0] = 1'b1;
      for (int i = 0; i < 7; i++) begin step(); cnt_ev += int'(gpio_fall[0]); end
      gpio_in[0] = 1'b0;
      for (int i = 0; i < 7; i++) begin step(); cnt_ev += int'(gpio_fall[0]); end
    end
    for (int i = 0; i < 8; i++) begin step(); cnt_ev += int'(gpio_fall[0]); end
    chk("t3_falls", 32'(cnt_ev), 32'd20);
    chk("t3_count_sat", 32'(evt_count[CW-1:0]), 32'(CMAX));

    // 4: clear coincident with a rise keeps the event, single ack
    gpio_in[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin step(); if (m_rise[0]) begin found = 1'b1; break; end end
    chk("t4_rise_seen", 32'(found), 32'd1);
    clr_if.clr_req = 1'b1; clr_if.clr_sel = 2'b01;
    cnt_ev = 0;
    for (int i = 0; i < 10; i++) begin step(); cnt_ev += int'(clr_if.clr_ack); end
    chk("t4_acks", 32'(cnt_ev), 32'd1);
    chk("t4_sticky", 32'(sticky[0]), 32'd1);
    chk("t4_count", 32'(evt_count[CW-1:0]), 32'd1);
    clr_if.clr_req = 1'b0;
    steps(3);

    // 5: cattrip latches, survives clear, cleared only by reset
    gpio_in[1] = 1'b1;
    steps(6);
    gpio_in[1] = 1'b0;
    steps(10);
    chk("t5_cattrip", 32'(hbm_cattrip_o), 32'd1);
    clr_if.clr_req = 1'b1; clr_if.clr_sel = 2'b11;
    steps(3);
    clr_if.clr_req = 1'b0;
    steps(3);
    chk("t5_sticky_clr", 32'(sticky), 32'd0);
    chk("t5_cattrip_held", 32'(hbm_cattrip_o), 32'd1);
    pulse_reset();
    chk("t5_cattrip_rst", 32'(hbm_cattrip_o), 32'd0);

    // 6: reset mid-debounce, input re-qualified from scratch
    gpio_in = 2'b01;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin step(); if (m_run[0] == 2) begin found = 1'b1; break; end end
    chk("t6_mid_debounce", 32'(found), 32'd1);
    pulse_reset();
    chk("t6_outputs_rst", 32'({gpio_level, sticky, evt_count, irq, hbm_cattrip_o}), 32'd0);
    k = 0;
    for (int i = 1; i <= 20; i++) begin step(); if (gpio_level[0]) begin k = i; break; end end
    chk("t6_latency", 32'(k), 32'(D + 2));
    step();
    chk("t6_count", 32'(evt_count[CW-1:0]), 32'd1);

    // Randomised traffic: glitches, masks and clears against the model
    hold0 = 1; hold1 = 1;
    for (int c = 0; c < 600; c++) begin
      if (--hold0 == 0) begin gpio_in[0] = 1'($urandom); hold0 = $urandom_range(1, 8); end
      if (--hold1 == 0) begin gpio_in[1] = 1'($urandom); hold1 = $urandom_range(1, 8); end
      if ($urandom_range(0, 15) == 0) gpio_mask = 2'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        clr_if.clr_req = ~clr_if.clr_req;
        clr_if.clr_sel = 2'($urandom);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
